multicycle_control: RTL and testbench

- Main sequencing FSM for the multi-cycle RISC core.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the datapath enables and the 4-bit ALU operation code.
- Handshakes with the shared instruction/data memory port, tracks retired instructions and flags memory timeouts.

---
 rtl/multicycle_control.sv | 157 +++++++++++++++
 tb/tb_multicycle_control.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RISC core
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       opCode,
    input  logic [4:0]       funCode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_is_data,
    output logic             alu_src_imm,
    output logic [3:0]       alu_op,
    output logic             reg_write,
    output logic             wb_from_mem,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TO_LAST = WW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR} state_t;
    typedef enum logic [2:0] {C_NOP, C_R, C_HALT, C_JUMP, C_IMM, C_BRANCH, C_LOAD, C_STORE} cls_t;

    state_t        state;
    cls_t          cls;
    cls_t          dec_cls;
    state_t        decode_nxt;
    state_t        exec_nxt;
    state_t        mem_nxt;
    logic [3:0]    dec_op;
    logic [WW-1:0] wait_cnt;
    logic [7:0]    mo;
    logic          unused_fun;

    // Moore output vector for a state/class pair:
    // {mem_read, mem_write, mem_is_data, alu_src_imm, reg_write, wb_from_mem, halted, error}
    function automatic logic [7:0] moore(input state_t s, input cls_t c);
        moore = {s == S_FETCH || (s == S_MEM && c == C_LOAD),
                 s == S_MEM && c == C_STORE,
                 s == S_MEM,
                 s == S_EXEC && (c == C_IMM || c == C_LOAD || c == C_STORE),
                 s == S_WB,
                 s == S_WB && c == C_LOAD,
                 s == S_HALT,
                 s == S_ERROR};
    endfunction

    // Instruction class from the opcode currently in the instruction register
    always_comb begin
        dec_cls = C_NOP;
        casez (opCode)
            6'b000000: dec_cls = C_R;
            6'b000001: dec_cls = C_HALT;
            6'b000010: dec_cls = C_JUMP;
            6'b001???: dec_cls = C_IMM;
            6'b01????: dec_cls = C_BRANCH;
            6'b1?0???: dec_cls = C_LOAD;
            6'b1?1???: dec_cls = C_STORE;
            default:   dec_cls = C_NOP;
        endcase
    end

    assign dec_op = opCode[5]                                   ? 4'b0000 :
                    opCode == 6'b000000                         ? funCode[3:0] :
                    (opCode == 6'b001000 || opCode[5:4] == 2'b01) ? 4'b0001 :
                    opCode == 6'b001001                         ? 4'b0101 :
                    opCode == 6'b001111                         ? 4'b0100 : 4'b0000;
    assign unused_fun = funCode[4];

    assign decode_nxt = dec_cls == C_HALT ? S_HALT : S_EXEC;
    assign exec_nxt   = (cls == C_LOAD || cls == C_STORE) ? S_MEM :
                        (cls == C_R || cls == C_IMM)      ? S_WB  : S_FETCH;
    assign mem_nxt    = cls == C_LOAD ? S_WB : S_FETCH;

    assign {mem_read, mem_write, mem_is_data, alu_src_imm, reg_write, wb_from_mem, halted, error} = mo;

    // Handshake- and branch-dependent strobes stay combinational so they land in the same cycle
    assign ir_write = state == S_FETCH && mem_ready;
    assign pc_write = ir_write ||
                      (state == S_EXEC && (cls == C_JUMP || (cls == C_BRANCH && branch_taken)));

    // Sequencer: state, latched class/alu_op, wait counter, retire counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cls         <= C_NOP;
            alu_op      <= 4'b0000;
            wait_cnt    <= '0;
            instr_count <= '0;
            mo          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (start) begin
                        state <= S_FETCH;
                        mo    <= moore(S_FETCH, cls);
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        state <= S_DECODE;
                        mo    <= moore(S_DECODE, cls);
                    end else if (wait_cnt == TO_LAST) begin
                        state <= S_ERROR;
                        mo    <= moore(S_ERROR, cls);
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_DECODE: begin
                    state    <= decode_nxt;
                    cls      <= dec_cls;
                    alu_op   <= dec_op;
                    wait_cnt <= '0;
                    mo       <= moore(decode_nxt, dec_cls);
                end
                S_EXEC: begin
                    state    <= exec_nxt;
                    wait_cnt <= '0;
                    mo       <= moore(exec_nxt, cls);
                    if (exec_nxt == S_FETCH) instr_count <= instr_count + CNT_W'(1);
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state    <= mem_nxt;
                        wait_cnt <= '0;
                        mo       <= moore(mem_nxt, cls);
                        if (mem_nxt == S_FETCH) instr_count <= instr_count + CNT_W'(1);
                    end else if (wait_cnt == TO_LAST) begin
                        state <= S_ERROR;
                        mo    <= moore(S_ERROR, cls);
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_WB: begin
                    state       <= S_FETCH;
                    wait_cnt    <= '0;
                    mo          <= moore(S_FETCH, cls);
                    instr_count <= instr_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized self-checking bench for the multi-cycle sequencer
module tb_multicycle_control;

    localparam int CW = 8;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          start = 0;
    logic [5:0]    opCode = 0;
    logic [4:0]    funCode = 0;
    logic          branch_taken = 0;
    logic          mem_ready = 0;
    logic          pc_write, ir_write, mem_read, mem_write, mem_is_data, alu_src_imm;
    logic [3:0]    alu_op;
    logic          reg_write, wb_from_mem, halted, error;
    logic [CW-1:0] instr_count;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [CW-1:0] m_count = 0;

    multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opCode(opCode), .funCode(funCode),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .pc_write(pc_write),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_is_data(mem_is_data), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
        .reg_write(reg_write), .wb_from_mem(wb_from_mem), .halted(halted), .error(error),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference classification: 1 R, 2 HALT, 3 JUMP, 4 IMM, 5 BRANCH, 6 LOAD, 7 STORE, 0 NOP
    function automatic int m_class(input logic [5:0] op);
        if (op == 0) return 1;
        if (op == 1) return 2;
        if (op == 2) return 3;
        if (op[5:3] == 3'b001) return 4;
        if (op[5:4] == 2'b01) return 5;
        if (op[5] && !op[3]) return 6;
        if (op[5] && op[3]) return 7;
        return 0;
    endfunction

    function automatic logic [3:0] m_aluop(input logic [5:0] op, input logic [4:0] fun);
        if (op[5]) return 4'd0;
        if (op == 0) return fun[3:0];
        if (op == 6'd8 || op[5:4] == 2'b01) return 4'd1;
        if (op == 6'd9) return 4'd5;
        if (op == 6'd15) return 4'd4;
        return 4'd0;
    endfunction

    function automatic logic [11:0] outs();
        return {pc_write, ir_write, mem_read, mem_write, mem_is_data, alu_src_imm,
                reg_write, wb_from_mem, halted, error, alu_op == 0 ? 1'b0 : 1'b1, instr_count != 0};
    endfunction

    task automatic do_reset();
        rst_n = 0; start = 0; mem_ready = 0; opCode = 0; funCode = 0; branch_taken = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        m_count = 0;
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge of the first FETCH cycle
    task automatic kick();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    // Runs one non-HALT instruction from the negedge of its first FETCH cycle to the next one
    task automatic run_instr(input logic [5:0] op, input logic [4:0] fun, input logic bt,
                             input int fw, input int mw, input string tag);
        int c, cyc, fcnt, dcnt, n_rw, n_wbm, n_pc, n_ir, n_mw, n_mrd, n_imm;
        int e_cyc, e_pc;
        bit done, prev_fetch, fetch, has_mem, has_wb;
        logic [3:0] last_op;
        c = m_class(op);
        has_mem = c == 6 || c == 7;
        has_wb = c == 1 || c == 4 || c == 6;
        e_cyc = fw + 3 + (has_mem ? mw + 1 : 0) + (has_wb ? 1 : 0);
        e_pc = 1 + ((c == 3 || (c == 5 && bt)) ? 1 : 0);
        m_count = m_count + 1'b1;
        {cyc, fcnt, dcnt, n_rw, n_wbm, n_pc, n_ir, n_mw, n_mrd, n_imm} = '0;
        done = 0; prev_fetch = 1; last_op = 'x;
        opCode = op; funCode = fun; branch_taken = bt;
        for (int k = 0; k < 200 && !done; k++) begin
            if (k > 0) @(negedge clk);
            fetch = mem_read && !mem_is_data;
            if (k > 0 && fetch && !prev_fetch) begin
                done = 1;
                mem_ready = 0;
            end else begin
                if (fetch) begin mem_ready = fcnt == fw; fcnt++; end
                else if (mem_is_data) begin mem_ready = dcnt == mw; dcnt++; end
                else mem_ready = 1'($urandom_range(0, 1));
                #1;
                cyc++;
                if (reg_write) n_rw++;
                if (wb_from_mem) n_wbm++;
                if (pc_write) n_pc++;
                if (ir_write) n_ir++;
                if (mem_write) n_mw++;
                if (mem_read && mem_is_data) n_mrd++;
                if (alu_src_imm) n_imm++;
                last_op = alu_op;
                prev_fetch = fetch;
            end
        end
        n_cmp += 12;
        if (!done) begin n_bad++; $display("FAIL %s next_fetch: not reached, error=%b halted=%b", tag, error, halted); end
        if (cyc !== e_cyc) begin n_bad++; $display("FAIL %s cycles: got %0d want %0d", tag, cyc, e_cyc); end
        if (n_rw !== int'(has_wb)) begin n_bad++; $display("FAIL %s reg_write_cycles: got %0d want %0d", tag, n_rw, has_wb); end
        if (n_wbm !== int'(c == 6)) begin n_bad++; $display("FAIL %s wb_from_mem_cycles: got %0d want %0d", tag, n_wbm, c == 6); end
        if (n_pc !== e_pc) begin n_bad++; $display("FAIL %s pc_write_cycles: got %0d want %0d", tag, n_pc, e_pc); end
        if (n_ir !== 1) begin n_bad++; $display("FAIL %s ir_write_cycles: got %0d want 1", tag, n_ir); end
        if (n_mw !== (c == 7 ? mw + 1 : 0)) begin n_bad++; $display("FAIL %s mem_write_cycles: got %0d want %0d", tag, n_mw, c == 7 ? mw + 1 : 0); end
        if (n_mrd !== (c == 6 ? mw + 1 : 0)) begin n_bad++; $display("FAIL %s data_read_cycles: got %0d want %0d", tag, n_mrd, c == 6 ? mw + 1 : 0); end
        if (n_imm !== int'(c == 4 || c == 6 || c == 7)) begin n_bad++; $display("FAIL %s alu_src_imm_cycles: got %0d want %0d", tag, n_imm, c == 4 || c == 6 || c == 7); end
        if (last_op !== m_aluop(op, fun)) begin n_bad++; $display("FAIL %s alu_op: got %h want %h", tag, last_op, m_aluop(op, fun)); end
        if (instr_count !== m_count) begin n_bad++; $display("FAIL %s instr_count: got %0d want %0d", tag, instr_count, m_count); end
        if (halted !== 1'b0 || error !== 1'b0) begin n_bad++; $display("FAIL %s sticky_flags: got %b%b want 00", tag, halted, error); end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp += 2;
        if (outs() !== 12'h000) begin n_bad++; $display("FAIL reset_outputs: got %h want 000", outs()); end
        if (instr_count !== 0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", instr_count); end
        mem_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (mem_read !== 1'b0) begin n_bad++; $display("FAIL idle_no_start: mem_read got %b want 0", mem_read); end
        mem_ready = 0;
        @(negedge clk);
    endtask

    task automatic test_rtype();
        kick();
        run_instr(6'b000000, 5'b00001, 0, 0, 0, "rtype_add");
    endtask

    task automatic test_load_delay();
        run_instr(6'b100011, 5'($urandom), 0, 0, 3, "load_wait3");
    endtask

    task automatic test_branch();
        run_instr(6'b010000, 5'($urandom), 1, 0, 0, "branch_taken");
        run_instr(6'b010000, 5'($urandom), 0, 0, 0, "branch_not_taken");
        run_instr(6'b000010, 5'($urandom), 0, 1, 0, "jump");
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 6'($urandom_range(0, 63));
            if (op == 6'd1) op = 6'd0;
            run_instr(op, 5'($urandom), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_boundary();
        run_instr(6'b001001, 5'($urandom), 0, 15, 0, "fetch_ready_at_limit");
        run_instr(6'b110000, 5'($urandom), 0, 0, 15, "load_ready_at_limit");
        run_instr(6'b101000, 5'($urandom), 0, 2, 15, "store_ready_at_limit");
    endtask

    task automatic test_wrap_halt();
        while (m_count != {CW{1'b1}}) run_instr(6'b000011, 5'($urandom), 0, 0, 0, "nop_fill");
        run_instr(6'b000111, 5'($urandom), 0, 0, 0, "count_wrap");
        n_cmp++;
        if (instr_count !== 0) begin n_bad++; $display("FAIL count_wrap_zero: got %0d want 0", instr_count); end
        opCode = 6'b000001; mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        @(negedge clk);
        #1;
        n_cmp += 3;
        if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_flag: got %b want 1", halted); end
        if (mem_read !== 1'b0 || reg_write !== 1'b0 || pc_write !== 1'b0) begin n_bad++; $display("FAIL halt_enables: got rd=%b rw=%b pc=%b want 000", mem_read, reg_write, pc_write); end
        if (instr_count !== 0) begin n_bad++; $display("FAIL halt_count: got %0d want 0", instr_count); end
        for (int i = 0; i < 4; i++) begin
            start = 1; mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 0;
        #1;
        n_cmp += 2;
        if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_sticky: got %b want 1", halted); end
        if (mem_read !== 1'b0 || ir_write !== 1'b0) begin n_bad++; $display("FAIL halt_start_ignored: got rd=%b ir=%b want 00", mem_read, ir_write); end
    endtask

    task automatic test_timeout();
        int fc;
        do_reset();
        kick();
        fc = 0;
        mem_ready = 0;
        while (mem_read && fc < 40) begin
            fc++;
            @(negedge clk);
        end
        #1;
        n_cmp += 4;
        if (fc !== 16) begin n_bad++; $display("FAIL timeout_cycles: got %0d want 16", fc); end
        if (error !== 1'b1) begin n_bad++; $display("FAIL timeout_error: got %b want 1", error); end
        if (mem_read !== 1'b0 || ir_write !== 1'b0) begin n_bad++; $display("FAIL timeout_req: got rd=%b ir=%b want 00", mem_read, ir_write); end
        if (halted !== 1'b0) begin n_bad++; $display("FAIL timeout_halted: got %b want 0", halted); end
        for (int i = 0; i < 4; i++) begin
            start = 1; mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 0;
        #1;
        n_cmp += 2;
        if (error !== 1'b1) begin n_bad++; $display("FAIL error_sticky: got %b want 1", error); end
        if (mem_read !== 1'b0) begin n_bad++; $display("FAIL error_start_ignored: mem_read got %b want 0", mem_read); end
    endtask

    task automatic test_reset_mid_store();
        do_reset();
        kick();
        run_instr(6'b000000, 5'b00010, 0, 0, 0, "pre_store_rtype");
        opCode = 6'b101011; mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (mem_write !== 1'b1 || mem_is_data !== 1'b1) begin n_bad++; $display("FAIL store_in_mem: got wr=%b data=%b want 11", mem_write, mem_is_data); end
        #2;
        rst_n = 0;
        #1;
        n_cmp += 2;
        if (outs() !== 12'h000) begin n_bad++; $display("FAIL async_reset_outputs: got %h want 000", outs()); end
        if (mem_write !== 1'b0) begin n_bad++; $display("FAIL async_reset_mem_write: got %b want 0", mem_write); end
        @(negedge clk);
        rst_n = 1;
        m_count = 0;
        repeat (3) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (mem_read !== 1'b0 || instr_count !== 0) begin n_bad++; $display("FAIL reset_to_idle: got rd=%b cnt=%0d want 0 0", mem_read, instr_count); end
        mem_ready = 0;
        kick();
        run_instr(6'b001111, 5'($urandom), 0, 1, 0, "after_reset_imm");
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_delay();
        test_branch();
        test_random();
        test_boundary();
        test_wrap_halt();
        test_timeout();
        test_reset_mid_store();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
